// File: rtl/cs_result_fifo_if.sv
// Result handshake bundle between cs_result_fifo and its consumer.
// Ports: out_data/out_valid driven by the FIFO (master), out_ready by the consumer (slave).
interface cs_result_fifo_if #(
    parameter int DW = 10
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/cs_result_fifo.sv
// Result FIFO behind the CS filter: drops warm-up outputs, then queues one Y per clock.
// Ports: clk, reset (sync, high), restart, y_in -> res (data/valid/ready), level, full,
// overflow, drop_cnt. Define CS_RESULT_STATS_EN to add y_min/y_max outputs.
module cs_result_fifo #(
    parameter int DW     = 10,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int WARMUP = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            restart,
    input  logic [DW-1:0]   y_in,
    cs_result_fifo_if.master res,
    output logic [AW:0]     level,
    output logic            full,
    output logic            overflow,
    output logic [7:0]      drop_cnt
`ifdef CS_RESULT_STATS_EN
    ,
    output logic [DW-1:0]   y_min,
    output logic [DW-1:0]   y_max
`endif
);
    localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] warm_cnt;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic clr;
    logic pop;
    logic push_req;
    logic push_ok;
    logic drop;

    assign clr = reset | restart;

    assign res.out_valid = (level != '0);
    assign res.out_data  = mem[rd_ptr];
    assign full          = (level == (AW+1)'(DEPTH));

    assign pop      = res.out_valid & res.out_ready;
    assign push_req = (state == RUN);
    // A full FIFO still takes the new sample if the head leaves on the same edge.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        state_n = state;
        unique case (state)
            WARM: if (warm_cnt == CW'(WARMUP - 1)) state_n = RUN;
            RUN:  state_n = RUN;
            default: state_n = WARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= WARM;
            warm_cnt <= '0;
        end else begin
            state <= state_n;
            if (state_n == WARM) warm_cnt <= warm_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Storage needs no reset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (!clr && push_ok) mem[wr_ptr] <= y_in;
    end

`ifdef CS_RESULT_STATS_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            y_min <= '1;
            y_max <= '0;
        end else if (push_ok) begin
            if (y_in < y_min) y_min <= y_in;
            if (y_in > y_max) y_max <= y_in;
        end
    end
`endif
endmodule

// File: tb/tb_cs_result_fifo.sv
// Bench for cs_result_fifo: directed phases plus random traffic vs a queue model.
// Ports: drives clk/reset/restart/y_in/out_ready, checks every output each cycle.
module tb_cs_result_fifo;
    localparam int DW     = 10;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int WARMUP = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          restart;
    logic [DW-1:0] y_in;
    logic [AW:0]   level;
    logic          full;
    logic          overflow;
    logic [7:0]    drop_cnt;
`ifdef CS_RESULT_STATS_EN
    logic [DW-1:0] y_min;
    logic [DW-1:0] y_max;
`endif

    cs_result_fifo_if #(.DW(DW)) rif ();

    cs_result_fifo #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .WARMUP(WARMUP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .y_in     (y_in),
        .res      (rif),
        .level    (level),
        .full     (full),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
`ifdef CS_RESULT_STATS_EN
        ,
        .y_min    (y_min),
        .y_max    (y_max)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: plain queue plus counters.
    int q[$];
    int warm_left;
    int m_ovf;
    int m_drop;
    int m_min;
    int m_max;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        q.delete();
        warm_left = WARMUP;
        m_ovf     = 0;
        m_drop    = 0;
        m_min     = (1 << DW) - 1;
        m_max     = 0;
    endtask

    task automatic model_edge(input bit rst, input bit rs, input int y,
                              input bit rdy);
        if (rst || rs) begin
            model_clear();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (warm_left > 0) begin
                warm_left--;
            end else if (q.size() < DEPTH) begin
                q.push_back(y);
                if (y < m_min) m_min = y;
                if (y > m_max) m_max = y;
            end else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(rif.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("out_data", 32'(rif.out_data), 32'(q[0]));
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`ifdef CS_RESULT_STATS_EN
        chk("y_min", 32'(y_min), 32'(m_min));
        chk("y_max", 32'(y_max), 32'(m_max));
`endif
    endtask

    task automatic step(input bit rst, input bit rs, input int y,
                        input bit rdy);
        reset         = rst;
        restart       = rs;
        y_in          = DW'(y);
        rif.out_ready = rdy;
        @(posedge clk);
        model_edge(rst, rs, y, rdy);
        #1;
        check_all();
    endtask

    initial begin
        int y;
        model_clear();
        reset = 1'b1; restart = 1'b0; y_in = '0; rif.out_ready = 1'b0;
        #2;

        // Phase 1: reset, then y_in = edge index with a ready consumer.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int e = 0; e < 30; e++) begin
            step(0, 0, e, 1);
            if (e == 8) chk("t1_no_valid", 32'(rif.out_valid), 32'd0);
            if (e == 9) chk("t1_first", 32'(rif.out_data), 32'h009);
        end

        // Phase 2: stalled consumer overflows the FIFO.
        for (int e = 0; e < 20; e++) step(0, 0, 'h100 + e, 0);
        chk("t2_full", 32'(full), 32'd1);
        for (int e = 0; e < 4; e++) step(0, 0, 'h200 + e, 0);

        // Phase 3: full with continuous push and pop across pointer wraps.
        for (int e = 0; e < 30; e++) step(0, 0, 'h300 + e, 1);
        chk("t3_level", 32'(level), 32'd8);

        // Phase 4: restart with level=5, then warm-up again.
        step(0, 1, 0, 0);
        for (int e = 0; e < WARMUP; e++) step(0, 0, 'h3F0, 0);
        for (int e = 0; e < 5; e++) step(0, 0, 'h050 + e, 0);
        chk("t4_level5", 32'(level), 32'd5);
        step(0, 1, 'h111, 1);
        chk("t4_flushed", 32'(level), 32'd0);
        for (int e = 0; e < WARMUP; e++) step(0, 0, 'h0AA, 1);
        step(0, 0, 'h2C3, 1);
        chk("t4_tenth", 32'(rif.out_data), 32'h2C3);

        // Phase 5: random traffic with occasional restart and reset.
        for (int e = 0; e < 400; e++) begin
            y = int'($urandom_range(0, (1 << DW) - 1));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 59) == 0,
                 y, 1'($urandom_range(0, 2) == 0));
        end

        // Phase 5b: reset mid-stream with a toggling consumer.
        for (int e = 0; e < 12; e++) step(0, 0, 'h1E0 + e, e[0]);
        step(1, 0, 'h3FF, 1);
        chk("t5_level", 32'(level), 32'd0);
        for (int e = 0; e < WARMUP; e++) step(0, 0, 'h077, e[0]);
        step(0, 0, 'h0BB, 0);
        chk("t5_capture", 32'(rif.out_data), 32'h0BB);

        // Phase 6: min/max tracking excludes dropped samples.
        step(0, 1, 0, 0);
        for (int e = 0; e < WARMUP; e++) step(0, 0, 'h001, 0);
        step(0, 0, 'h120, 0);
        step(0, 0, 'h3FF, 0);
        step(0, 0, 'h005, 0);
        for (int e = 0; e < 5; e++) step(0, 0, 'h100, 0);
        step(0, 0, 'h000, 0);
        chk("t6_drop", 32'(drop_cnt), 32'd1);
`ifdef CS_RESULT_STATS_EN
        chk("t6_min", 32'(y_min), 32'h005);
        chk("t6_max", 32'(y_max), 32'h3FF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
